// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the RV memory responder: access sizes, lane strobes,
// offset alignment and stall-LFSR constants.
package rv_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } data_req_t;

  // Fibonacci LFSR, taps 16,14,13,11 in right-shift form (feedback into bit 15).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return off;
      SZ_HALF: return {off[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 4'b0001 << off;
      SZ_HALF: return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/rv_mem_chan.sv
// One response channel: fixed-latency in-order delay line, outstanding-read counter and ready.
// RV_MEM_STALL_EN adds an LFSR that randomly forces ready low.
module rv_mem_chan
  import rv_mem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_accept,
  input  logic [31:0] rd_word,
  input  logic        bypass,
  output logic        ready_c,
  output logic        rsp_valid,
  output logic [31:0] rsp_data
);

  localparam int unsigned CW = 4;

  logic [LATENCY-1:0] pv;
  logic [31:0]        pd [LATENCY];
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_next;
  logic               leave;
  logic               go;

  // A read stops counting one cycle before its pulse so DEPTH reads sustain DEPTH per LATENCY.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign leave = rd_accept;
    end else begin : g_latn
      assign leave = pv[LATENCY-2];
    end
  endgenerate

`ifdef RV_MEM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  end

  assign go = (lfsr[1:0] != 2'b00);
`else
  assign go = 1'b1;
`endif

  always_comb begin
    cnt_next = cnt;
    if (rd_accept && !leave)      cnt_next = cnt + CW'(1);
    else if (!rd_accept && leave) cnt_next = cnt - CW'(1);
  end

  assign ready_c = go && ((cnt < CW'(DEPTH)) || bypass);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      pv        <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      cnt   <= cnt_next;
      pv[0] <= rd_accept;
      for (int i = 1; i < int'(LATENCY); i++) pv[i] <= pv[i-1];
      rsp_valid <= pv[LATENCY-1];
      if (pv[LATENCY-1]) rsp_data <= pd[LATENCY-1];
    end
  end

  // Data stages carry no reset; only the valid bits matter after reset.
  always_ff @(posedge clk) begin
    pd[0] <= rd_word;
    for (int i = 1; i < int'(LATENCY); i++) pd[i] <= pd[i-1];
  end

endmodule

// File: rtl/rv_mem_responder.sv
// Memory-side responder for the RV split instruction/data buses: word array, byte lanes, two channels.
// Optional macro RV_MEM_STALL_EN enables LFSR stall injection on both ready outputs.
module rv_mem_responder
  import rv_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned DEPTH     = 4,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_req_valid,
  output logic        instr_req_ready,
  input  logic [31:0] instr_req_addr,
  output logic        instr_rsp_valid,
  output logic [31:0] instr_rsp_data,
  input  logic        data_req_valid,
  output logic        data_req_ready,
  input  logic        data_req_wr,
  input  logic [1:0]  data_req_size,
  input  logic [31:0] data_req_data,
  input  logic [31:0] data_req_addr,
  output logic        data_rsp_valid,
  output logic [31:0] data_rsp_data
);

  localparam int unsigned AW = $clog2(MEM_WORDS);

  logic [31:0]   mem [MEM_WORDS];
  data_req_t     dreq;
  logic [AW-1:0] i_idx;
  logic [AW-1:0] d_idx;
  logic [1:0]    d_off;
  logic [3:0]    d_mask;
  logic [31:0]   d_wdata;
  logic [31:0]   i_word;
  logic [31:0]   d_word;
  logic [31:0]   d_shift;
  logic [31:0]   d_load;
  logic          i_acc;
  logic          d_acc;
  logic          unused_addr_bits;

  assign dreq = {data_req_wr, data_req_size, data_req_addr, data_req_data};

  assign i_idx   = instr_req_addr[AW+1:2];
  assign d_idx   = dreq.addr[AW+1:2];
  assign d_off   = align_offset(dreq.size, dreq.addr[1:0]);
  assign d_mask  = lane_mask(dreq.size, d_off);
  assign d_wdata = dreq.data << {d_off, 3'b000};

  assign unused_addr_bits = ^{instr_req_addr[31:AW+2], instr_req_addr[1:0], dreq.addr[31:AW+2]};

  assign i_acc = instr_req_valid && instr_req_ready;
  assign d_acc = data_req_valid && data_req_ready;

  always_comb begin
    i_word  = mem[i_idx];
    d_word  = mem[d_idx];
    d_shift = d_word >> {d_off, 3'b000};
    d_load  = d_shift;
    case (dreq.size)
      SZ_BYTE: d_load = {24'h0, d_shift[7:0]};
      SZ_HALF: d_load = {16'h0, d_shift[15:0]};
      default: d_load = d_shift;
    endcase
  end

  // Store lands at the edge, so a same-cycle fetch of that word still reads the old value.
  always_ff @(posedge clk) begin
    if (d_acc && dreq.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (d_mask[i]) mem[d_idx][8*i +: 8] <= d_wdata[8*i +: 8];
      end
    end
  end

  rv_mem_chan #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) u_instr_chan (
    .clk       (clk),
    .reset     (reset),
    .rd_accept (i_acc),
    .rd_word   (i_word),
    .bypass    (1'b0),
    .ready_c   (instr_req_ready),
    .rsp_valid (instr_rsp_valid),
    .rsp_data  (instr_rsp_data)
  );

  rv_mem_chan #(
    .LATENCY (LATENCY),
    .DEPTH   (DEPTH)
  ) u_data_chan (
    .clk       (clk),
    .reset     (reset),
    .rd_accept (d_acc && !dreq.wr),
    .rd_word   (d_load),
    .bypass    (dreq.wr),
    .ready_c   (data_req_ready),
    .rsp_valid (data_rsp_valid),
    .rsp_data  (data_rsp_data)
  );

endmodule

// File: tb/tb_rv_mem_responder.sv
// Directed bench for rv_mem_responder: a default instance (LATENCY 2, DEPTH 4)
// and a LATENCY 4 / DEPTH 2 instance for the occupancy-limit case.
module tb_rv_mem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        iv, ir, irv;
  logic [31:0] ia, ird;
  logic        dv, dr, dw, drv;
  logic [1:0]  ds;
  logic [31:0] dd, da, drd;

  logic        iv4, ir4, irv4;
  logic [31:0] ia4, ird4;
  logic        dv4, dr4, dw4, drv4;
  logic [1:0]  ds4;
  logic [31:0] dd4, da4, drd4;

  int ncmp  = 0;
  int nfail = 0;

  rv_mem_responder dut (
    .clk(clk), .reset(reset),
    .instr_req_valid(iv), .instr_req_ready(ir), .instr_req_addr(ia),
    .instr_rsp_valid(irv), .instr_rsp_data(ird),
    .data_req_valid(dv), .data_req_ready(dr), .data_req_wr(dw), .data_req_size(ds),
    .data_req_data(dd), .data_req_addr(da), .data_rsp_valid(drv), .data_rsp_data(drd)
  );

  rv_mem_responder #(.MEM_WORDS(64), .LATENCY(4), .DEPTH(2)) dut4 (
    .clk(clk), .reset(reset),
    .instr_req_valid(iv4), .instr_req_ready(ir4), .instr_req_addr(ia4),
    .instr_rsp_valid(irv4), .instr_rsp_data(ird4),
    .data_req_valid(dv4), .data_req_ready(dr4), .data_req_wr(dw4), .data_req_size(ds4),
    .data_req_data(dd4), .data_req_addr(da4), .data_rsp_valid(drv4), .data_rsp_data(drd4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic dstore(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    dv = 1'b1; dw = 1'b1; ds = sz; da = a; dd = d;
    #1 chk("st_ready", 32'(dr), 32'd1);
    tick();
    dv = 1'b0; dw = 1'b0;
    chk("st_norsp", 32'(drv), 32'd0);
  endtask

  task automatic dload(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] exp,
                       input string tag);
    dv = 1'b1; dw = 1'b0; ds = sz; da = a;
    #1 chk({tag, "_rdy"}, 32'(dr), 32'd1);
    tick();
    dv = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      chk({tag, "_early"}, 32'(drv), 32'd0);
      tick();
    end
    chk({tag, "_vld"}, 32'(drv), 32'd1);
    chk(tag, drd, exp);
    tick();
    chk({tag, "_pulse"}, 32'(drv), 32'd0);
    chk({tag, "_hold"}, drd, exp);
  endtask

  task automatic ifetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
    iv = 1'b1; ia = a;
    #1 chk({tag, "_rdy"}, 32'(ir), 32'd1);
    tick();
    iv = 1'b0;
    for (int k = 0; k < LAT; k++) begin
      chk({tag, "_early"}, 32'(irv), 32'd0);
      tick();
    end
    chk({tag, "_vld"}, 32'(irv), 32'd1);
    chk(tag, ird, exp);
    tick();
    chk({tag, "_pulse"}, 32'(irv), 32'd0);
  endtask

  initial begin
    int nacc;
    int nrsp;
    logic prev_rdy;
    logic exp_rdy;
    logic exp_rv;

    reset = 1'b1;
    iv = 1'b0; ia = '0;
    dv = 1'b0; dw = 1'b0; ds = 2'd2; dd = '0; da = '0;
    iv4 = 1'b0; ia4 = '0;
    dv4 = 1'b0; dw4 = 1'b0; ds4 = 2'd2; dd4 = '0; da4 = '0;
    repeat (3) tick();

    chk("rst_iready", 32'(ir), 32'd1);
    chk("rst_dready", 32'(dr), 32'd1);
    chk("rst_irv", 32'(irv), 32'd0);
    chk("rst_drv", 32'(drv), 32'd0);
    chk("rst_ird", ird, 32'd0);
    chk("rst_drd", drd, 32'd0);
    chk("rst_iready4", 32'(ir4), 32'd1);
    reset = 1'b0;
    tick();

    dstore(2'd2, 32'h100, 32'hDEADBEEF);
    dload(2'd2, 32'h100, 32'hDEADBEEF, "ld_word");

    dstore(2'd2, 32'h100, 32'h11223344);
    dstore(2'd0, 32'h103, 32'hFFFFFF5A);
    dload(2'd2, 32'h100, 32'h5A223344, "ld_after_byte_st");
    dload(2'd1, 32'h102, 32'h00005A22, "ld_half_hi");

    dstore(2'd2, 32'h100, 32'h11223344);
    dload(2'd1, 32'h101, 32'h00003344, "ld_half_misalign");
    dload(2'd0, 32'h102, 32'h00000022, "ld_byte");
    dstore(2'd1, 32'h103, 32'hAAAABEEF);
    dload(2'd3, 32'h100, 32'hBEEF3344, "ld_size3");

    // Same-cycle fetch and aliased store to one word.
    dstore(2'd2, 32'h200, 32'h0);
    iv = 1'b1; ia = 32'h200;
    dv = 1'b1; dw = 1'b1; ds = 2'd2; da = 32'h1200; dd = 32'hCAFEF00D;
    #1 tick();
    iv = 1'b0; dv = 1'b0; dw = 1'b0;
    chk("coll_early0", 32'(irv), 32'd0);
    tick();
    chk("coll_early1", 32'(irv), 32'd0);
    tick();
    chk("coll_vld", 32'(irv), 32'd1);
    chk("coll_old", ird, 32'h0);
    tick();
    ifetch(32'h200, 32'hCAFEF00D, "fetch_new");
    dload(2'd2, 32'h1200, 32'hCAFEF00D, "ld_alias");

    // Three reads in flight, then reset.
    iv = 1'b1; ia = 32'h100;
    tick();
    ia = 32'h200;
    dv = 1'b1; dw = 1'b0; ds = 2'd2; da = 32'h100;
    #1 chk("inflight_iready", 32'(ir), 32'd1);
    tick();
    iv = 1'b0; dv = 1'b0; reset = 1'b1;
    tick();
    chk("inrst_irv", 32'(irv), 32'd0);
    chk("inrst_drv", 32'(drv), 32'd0);
    reset = 1'b0;
    tick();
    chk("postrst_iready", 32'(ir), 32'd1);
    chk("postrst_dready", 32'(dr), 32'd1);
    chk("postrst_drd", drd, 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("postrst_irv", 32'(irv), 32'd0);
      chk("postrst_drv", 32'(drv), 32'd0);
      tick();
    end
    ifetch(32'h200, 32'hCAFEF00D, "keep_fetch");
    dload(2'd2, 32'h100, 32'hBEEF3344, "keep_load");

    // LATENCY 4 / DEPTH 2: preload words, then hold fetch valid.
    for (int j = 0; j < 6; j++) begin
      dv4 = 1'b1; dw4 = 1'b1; ds4 = 2'd2; da4 = 32'(4 * j); dd4 = 32'hA0000000 + 32'(j);
      tick();
    end
    dv4 = 1'b0; dw4 = 1'b0;
    tick();

    nacc = 0; nrsp = 0; prev_rdy = 1'b1;
    iv4 = 1'b1; ia4 = 32'h0;
    #1 chk("d2_rdy_init", 32'(ir4), 32'd1);
    for (int t = 0; t <= 14; t++) begin
      tick();
      if (iv4 && prev_rdy) nacc++;
      exp_rdy = (t >= 12) || (t % 4 == 0) || (t % 4 == 3);
      exp_rv  = (t >= 4) && (t <= 13) && (t % 4 < 2);
      chk($sformatf("d2_rdy_t%0d", t), 32'(ir4), 32'(exp_rdy));
      chk($sformatf("d2_rv_t%0d", t), 32'(irv4), 32'(exp_rv));
      if (exp_rv) begin
        chk($sformatf("d2_data_t%0d", t), ird4, 32'hA0000000 + 32'(nrsp));
        nrsp++;
      end
      ia4 = 32'(4 * nacc);
      iv4 = (t + 1 <= 11);
      prev_rdy = exp_rdy;
    end
    chk("d2_accepts", 32'(nacc), 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
